// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the RV32I load/store unit.
// Opcodes, funct3 access codes and the transaction state encoding.
package load_store_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane logic: legality, byte enables and store replication on the request
// side, lane extract and sign/zero extension on the response side.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_lo,
  input  logic [31:0] store_data,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic       sz_b;
  logic       sz_h;
  logic       sz_w;
  logic       ok_f3;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  assign sz_b = req_funct3[1:0] == 2'b00;
  assign sz_h = req_funct3[1:0] == 2'b01;
  assign sz_w = req_funct3[1:0] == 2'b10;

  // Stores have no unsigned forms; loads have no unsigned word.
  assign ok_f3 = req_store
               ? !req_funct3[2]
               : (req_funct3 != 3'b110) && (req_funct3 != 3'b111);

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wdata = store_data;
    unique case (1'b1)
      sz_b: begin
        legal = ok_f3;
        be    = 4'b0001 << req_lo;
        wdata = {4{store_data[7:0]}};
      end
      sz_h: begin
        legal = ok_f3 && !req_lo[0];
        be    = req_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      sz_w: begin
        legal = ok_f3 && (req_lo == 2'b00);
        be    = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = rdata[7:0];
    case (rsp_lo)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: ;
    endcase
  end

  assign lane_h = rsp_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = rdata;
    case (rsp_funct3)
      F3_B:  rdata_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU: rdata_ext = {24'b0, lane_b};
      F3_H:  rdata_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU: rdata_ext = {16'b0, lane_h};
      F3_W:  rdata_ext = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding word-addressed memory access,
// with request fields captured at acceptance and held until completion.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;
  logic        err_q;

  logic        is_ld;
  logic        is_st;
  logic        accept;
  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_c;

  assign is_ld  = opcode == OP_LOAD;
  assign is_st  = opcode == OP_STORE;
  assign accept = start && (state == S_IDLE) && (is_ld || is_st);

  lsu_align u_align (
    .req_store  (is_st),
    .req_funct3 (funct3),
    .req_lo     (addr[1:0]),
    .store_data (store_data),
    .legal      (legal),
    .be         (be_c),
    .wdata      (wdata_c),
    .rsp_funct3 (f3_q),
    .rsp_lo     (addr_q[1:0]),
    .rdata      (mem_rdata),
    .rdata_ext  (ext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      unique case (state)
        S_IDLE: begin
          if (accept && legal) begin
            state   <= S_REQ;
            addr_q  <= addr;
            f3_q    <= funct3;
            we_q    <= is_st;
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            state <= S_RESP;
            if (!we_q) load_q <= ext_c;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Driven straight from state so reset removes the request asynchronously.
  assign mem_req   = state == S_REQ;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = state != S_IDLE;
  assign done      = state == S_RESP;
  assign err       = err_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a scripted memory responder plus
// a completion monitor that pops expected results as done/err appear.
module tb_load_store_unit;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kind: 0 load done, 1 store done, 2 error
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", {done, err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("completion_kind", {done, err},
              (e.kind == 2) ? 2'b01 : 2'b10);
        if (e.kind == 0) check("load_data", load_data, e.data);
      end
    end
  end

  function automatic void model(input logic [2:0] f3,
                                input logic [31:0] a,
                                input logic [31:0] sd,
                                input logic [31:0] rd,
                                output logic [3:0] be,
                                output logic [31:0] wd,
                                output logic [31:0] ld);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    be = 4'b1111;
    wd = sd;
    ld = rd;
    case (f3[1:0])
      2'b00: begin
        be = 4'b0001 << a[1:0];
        wd = {4{sd[7:0]}};
        ld = f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        be = a[1] ? 4'b1100 : 4'b0011;
        wd = {2{sd[15:0]}};
        ld = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int waits, input logic [31:0] rd,
                        input logic [3:0] xbe, input logic [31:0] xwd,
                        input logic [31:0] xld, input bit xerr,
                        input bit poke);
    exp_t e;
    e.kind = xerr ? 2 : ((op == ST) ? 1 : 0);
    e.data = xld;
    sb.push_back(e);
    start = 1'b1;
    opcode = op;
    funct3 = f3;
    addr = a;
    store_data = sd;
    @(negedge clk);
    start = 1'b0;
    addr = $urandom;
    store_data = $urandom;
    funct3 = 3'($urandom);
    if (xerr) begin
      check("err_busy", busy, 1'b0);
      check("err_req", mem_req, 1'b0);
      @(negedge clk);
      check("err_pulse_end", err, 1'b0);
      check("err_req2", mem_req, 1'b0);
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      start = 1'b0;
      check("mem_req", mem_req, 1'b1);
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_be", mem_be, xbe);
      check("mem_we", mem_we, op == ST);
      if (op == ST) check("mem_wdata", mem_wdata, xwd);
      check("busy_req", busy, 1'b1);
      check("no_early_done", done, 1'b0);
      if (poke && i == 0) begin
        start = 1'b1;
        opcode = LD;
        funct3 = 3'b010;
        addr = a + 32'h40;
      end
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check("done_latency", done, 1'b1);
    if (poke) begin
      start = 1'b1;
      opcode = LD;
      funct3 = 3'b010;
      addr = a + 32'h80;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_end", done, 1'b0);
    check("busy_end", busy, 1'b0);
    check("req_end", mem_req, 1'b0);
  endtask

  initial begin
    logic [3:0]  rbe;
    logic [31:0] rwd;
    logic [31:0] rld;
    rst = 1'b1;
    start = 1'b0;
    opcode = '0;
    funct3 = '0;
    addr = '0;
    store_data = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", mem_be, 4'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_ldata", load_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op(LD, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF,
           4'b1111, 0, 32'hDEADBEEF, 0, 0);
    run_op(LD, 3'b000, 32'h103, 0, 1, 32'h80FF0000,
           4'b1000, 0, 32'hFFFFFF80, 0, 0);
    run_op(LD, 3'b100, 32'h103, 0, 0, 32'h80FF0000,
           4'b1000, 0, 32'h00000080, 0, 0);
    run_op(ST, 3'b001, 32'h202, 32'h1234ABCD, 3, $urandom,
           4'b1100, 32'hABCDABCD, 0, 0, 0);
    run_op(ST, 3'b000, 32'h001, 32'hAABBCC55, 0, $urandom,
           4'b0010, 32'h55555555, 0, 0, 0);
    run_op(LD, 3'b001, 32'h106, 0, 2, 32'h8001_1234,
           4'b1100, 0, 32'hFFFF8001, 0, 0);
    run_op(LD, 3'b101, 32'h104, 0, 0, 32'h1234_F00D,
           4'b0011, 0, 32'h0000F00D, 0, 0);
    run_op(ST, 3'b010, 32'h300, 32'hCAFEF00D, 1, $urandom,
           4'b1111, 32'hCAFEF00D, 0, 0, 0);

    run_op(LD, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 1, 0);
    run_op(LD, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
    run_op(ST, 3'b100, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
    run_op(ST, 3'b001, 32'h203, 0, 0, 0, 0, 0, 0, 1, 0);

    run_op(LD, 3'b010, 32'h500, 0, 2, 32'h0BADF00D,
           4'b1111, 0, 32'h0BADF00D, 0, 1);

    start = 1'b1;
    opcode = 7'b0110011;
    funct3 = 3'b010;
    addr = 32'h700;
    @(negedge clk);
    start = 1'b0;
    check("other_op_busy", busy, 1'b0);
    check("other_op_err", err, 1'b0);
    check("other_op_req", mem_req, 1'b0);

    mem_ready = 1'b1;
    mem_rdata = 32'h11111111;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready_busy", busy, 1'b0);
    end
    mem_ready = 1'b0;
    @(negedge clk);

    begin
      exp_t e;
      e.kind = 0;
      e.data = 0;
      sb.push_back(e);
    end
    start = 1'b1;
    opcode = LD;
    funct3 = 3'b010;
    addr = 32'h600;
    @(negedge clk);
    start = 1'b0;
    check("abort_req_a", mem_req, 1'b1);
    @(negedge clk);
    check("abort_req_b", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    mem_ready = 1'b0;
    run_op(LD, 3'b010, 32'h604, 0, 1, 32'h600DCAFE,
           4'b1111, 0, 32'h600DCAFE, 0, 0);

    for (int n = 0; n < 16; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rd;
      bit          is_st;
      is_st = n[0];
      a = $urandom & 32'h0000FFFF;
      sd = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 2))
        0: f3 = 3'b000;
        1: begin f3 = 3'b001; a[0] = 1'b0; end
        default: begin f3 = 3'b010; a[1:0] = 2'b00; end
      endcase
      if (!is_st && f3 != 3'b010 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      model(f3, a, sd, rd, rbe, rwd, rld);
      run_op(is_st ? ST : LD, f3, a, sd, $urandom_range(0, 3), rd,
             rbe, rwd, rld, 0, 0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
